// File: rtl/fm_guard_fetch.sv
`default_nettype none
// ============================================================================
// Module   : fm_guard_fetch
// Purpose  : Consumer end of the FM/guard buffer pair. For every 6-activation
//            group it reads the guard word, fetches only the activations
//            whose guard bit is set, and presents the group to the PE array
//            as a 6-lane vector. Guarded-off lanes are output as zero.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle job start pulse (sampled in IDLE only)
//   base_fm_addr_i         FM address of lane 0 of group 0
//   base_guard_addr_i      guard address of group 0
//   group_num_i            number of groups to fetch (0 = empty job)
//   busy_o / done_o        job in progress / one-cycle completion pulse
//   guard_rd_*             guard buffer read port (1-cycle read latency)
//   fm_rd_*                FM buffer read port (1-cycle read latency)
//   act_o, act_guard_o     activation vector and its guard mask
//   act_valid_o/act_ready_i  valid/ready handshake towards the PE array
// ============================================================================
module fm_guard_fetch #(
  parameter int FM_ADDR_W    = 16,
  parameter int GUARD_ADDR_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [FM_ADDR_W-1:0]    base_fm_addr_i,
  input  logic [GUARD_ADDR_W-1:0] base_guard_addr_i,
  input  logic [15:0]             group_num_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    guard_rd_en_o,
  output logic [GUARD_ADDR_W-1:0] guard_rd_addr_o,
  input  logic [5:0]              guard_rd_data_i,
  output logic                    fm_rd_en_o,
  output logic [FM_ADDR_W-1:0]    fm_rd_addr_o,
  input  logic [7:0]              fm_rd_data_i,
  output logic [5:0][7:0]         act_o,
  output logic [5:0]              act_guard_o,
  output logic                    act_valid_o,
  input  logic                    act_ready_i
);

  localparam logic [FM_ADDR_W-1:0]    c_FM_STRIDE    = FM_ADDR_W'(6);
  localparam logic [GUARD_ADDR_W-1:0] c_GUARD_STRIDE = GUARD_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_G_REQ   = 3'd1,
    S_G_WAIT  = 3'd2,
    S_F_RD    = 3'd3,
    S_F_DRAIN = 3'd4,
    S_OUT     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [FM_ADDR_W-1:0]    r_fm_ptr;     // FM address of lane 0, current group
  logic [GUARD_ADDR_W-1:0] r_guard_ptr;  // guard address, current group
  logic [15:0]             r_remain;     // groups still to hand over
  logic [5:0]              r_pending;    // guard bits not yet read from FM
  logic [2:0]              r_tag;        // lane of the single outstanding FM read
  logic                    r_rd_pend;    // an FM read was issued last cycle
  logic [5:0][7:0]         r_act;
  logic [5:0]              r_guard;

  logic [2:0]              w_lane;
  logic [5:0]              w_pending_clr;

  // Lowest set pending bit: scanning downwards lets the lowest index win.
  always_comb begin
    w_lane = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lane = 3'(i);
      end
    end
  end

  // Clearing the lowest set bit; zero here means the current read is the last.
  assign w_pending_clr = r_pending & (r_pending - 6'd1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    guard_rd_en_o = 1'b0;
    fm_rd_en_o    = 1'b0;
    act_valid_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (group_num_i != 16'd0) ? S_G_REQ : S_DONE;
        end
      end
      S_G_REQ: begin
        busy_o        = 1'b1;
        guard_rd_en_o = 1'b1;
        w_state_nxt   = S_G_WAIT;
      end
      S_G_WAIT: begin
        busy_o      = 1'b1;
        w_state_nxt = (guard_rd_data_i == 6'd0) ? S_OUT : S_F_RD;
      end
      S_F_RD: begin
        busy_o     = 1'b1;
        fm_rd_en_o = 1'b1;
        if (w_pending_clr == 6'd0) begin
          w_state_nxt = S_F_DRAIN;
        end
      end
      S_F_DRAIN: begin
        busy_o      = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        busy_o      = 1'b1;
        act_valid_o = 1'b1;
        if (act_ready_i) begin
          w_state_nxt = (r_remain == 16'd1) ? S_DONE : S_G_REQ;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: pointers, pending mask, lane capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fm_ptr    <= '0;
      r_guard_ptr <= '0;
      r_remain    <= '0;
      r_pending   <= '0;
      r_tag       <= '0;
      r_rd_pend   <= 1'b0;
      r_act       <= '0;
      r_guard     <= '0;
    end else begin
      r_rd_pend <= fm_rd_en_o;
      // The byte for the read issued last cycle lands in the tagged lane.
      if (r_rd_pend) begin
        r_act[r_tag] <= fm_rd_data_i;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fm_ptr    <= base_fm_addr_i;
            r_guard_ptr <= base_guard_addr_i;
            r_remain    <= group_num_i;
            r_act       <= '0;
          end
        end
        S_G_WAIT: begin
          r_guard   <= guard_rd_data_i;
          r_pending <= guard_rd_data_i;
          r_act     <= '0;
        end
        S_F_RD: begin
          r_pending <= w_pending_clr;
          r_tag     <= w_lane;
        end
        S_OUT: begin
          if (act_ready_i) begin
            r_remain    <= r_remain - 16'd1;
            r_fm_ptr    <= r_fm_ptr + c_FM_STRIDE;
            r_guard_ptr <= r_guard_ptr + c_GUARD_STRIDE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign guard_rd_addr_o = r_guard_ptr;
  assign fm_rd_addr_o    = r_fm_ptr + FM_ADDR_W'(w_lane);
  assign act_o           = r_act;
  assign act_guard_o     = r_guard;

endmodule
`default_nettype wire

// File: tb/tb_fm_guard_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_guard_fetch
// Purpose  : Self-checking bench for fm_guard_fetch. Buffer models answer
//            reads with one cycle of latency; each job's cycle-by-cycle
//            schedule is derived from the memory layout and group timing
//            rules, then compared against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_guard_fetch;

  localparam int MAXC = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [15:0]      base_fm_addr_i;
  logic [13:0]      base_guard_addr_i;
  logic [15:0]      group_num_i;
  logic             busy_o, done_o;
  logic             guard_rd_en_o;
  logic [13:0]      guard_rd_addr_o;
  logic [5:0]       guard_rd_data_i;
  logic             fm_rd_en_o;
  logic [15:0]      fm_rd_addr_o;
  logic [7:0]       fm_rd_data_i;
  logic [5:0][7:0]  act_o;
  logic [5:0]       act_guard_o;
  logic             act_valid_o;
  logic             act_ready_i;

  always #5 clk = ~clk;

  fm_guard_fetch #(.FM_ADDR_W(16), .GUARD_ADDR_W(14)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_fm_addr_i    (base_fm_addr_i),
    .base_guard_addr_i (base_guard_addr_i),
    .group_num_i       (group_num_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .guard_rd_en_o     (guard_rd_en_o),
    .guard_rd_addr_o   (guard_rd_addr_o),
    .guard_rd_data_i   (guard_rd_data_i),
    .fm_rd_en_o        (fm_rd_en_o),
    .fm_rd_addr_o      (fm_rd_addr_o),
    .fm_rd_data_i      (fm_rd_data_i),
    .act_o             (act_o),
    .act_guard_o       (act_guard_o),
    .act_valid_o       (act_valid_o),
    .act_ready_i       (act_ready_i)
  );

  // Buffer models: data one cycle after the strobe, junk otherwise.
  logic [7:0] fmem [0:65535];
  logic [5:0] gmem [0:16383];

  always @(posedge clk) begin
    guard_rd_data_i <= guard_rd_en_o ? gmem[guard_rd_addr_o] : 6'($urandom);
    fm_rd_data_i    <= fm_rd_en_o ? fmem[fm_rd_addr_o] : 8'($urandom);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Expected per-cycle schedule of one job.
  bit          e_gen   [0:MAXC-1];
  logic [13:0] e_gaddr [0:MAXC-1];
  bit          e_fen   [0:MAXC-1];
  logic [15:0] e_faddr [0:MAXC-1];
  bit          e_valid [0:MAXC-1];
  logic [47:0] e_vec   [0:MAXC-1];
  logic [5:0]  e_gmask [0:MAXC-1];
  bit          rdy     [0:MAXC-1];

  // stall < 0 picks a random 0..3 cycle stall per group; rnd_in scrambles
  // start and the job inputs after cycle 0 (they must be ignored).
  task automatic run_job(input logic [15:0] bf, input logic [13:0] bg, input logic [15:0] ng,
                         input int stall, input bit rnd_in,
                         output int first_valid, output int fm_reads, output int done_cyc,
                         output logic [47:0] last_act);
    int t0, n, tv, s, dc;
    logic [5:0]  gw;
    logic [13:0] ga;
    logic [15:0] fa;
    logic [47:0] vec;
    for (int c = 0; c < MAXC; c++) begin
      e_gen[c] = 0; e_fen[c] = 0; e_valid[c] = 0;
      e_gaddr[c] = '0; e_faddr[c] = '0; e_vec[c] = '0; e_gmask[c] = '0;
      rdy[c] = 1'($urandom_range(0, 1));
    end
    t0 = 0;
    for (int g = 0; g < int'(ng); g++) begin
      ga = 14'(int'(bg) + g);
      gw = gmem[ga];
      e_gen[t0+1] = 1; e_gaddr[t0+1] = ga;
      n = 0; vec = '0;
      for (int k = 0; k < 6; k++) begin
        if (gw[k]) begin
          n++;
          fa = 16'(int'(bf) + 6*g + k);
          e_fen[t0+2+n] = 1; e_faddr[t0+2+n] = fa;
          vec[8*k +: 8] = fmem[fa];
        end
      end
      tv = t0 + 3 + n + ((n > 0) ? 1 : 0);
      s  = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int c = tv; c <= tv + s; c++) begin
        e_valid[c] = 1; e_vec[c] = vec; e_gmask[c] = gw;
        rdy[c] = (c == tv + s);
      end
      t0 = tv + s;
    end
    dc = (ng == 16'd0) ? 1 : t0 + 1;

    first_valid = -1; fm_reads = 0; done_cyc = -1; last_act = '0;
    for (int c = 0; c <= dc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1;
        base_fm_addr_i = bf; base_guard_addr_i = bg; group_num_i = ng;
      end else if (rnd_in) begin
        start = 1'($urandom_range(0, 1));
        base_fm_addr_i = 16'($urandom); base_guard_addr_i = 14'($urandom);
        group_num_i = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      act_ready_i = rdy[c];
      @(negedge clk);
      chk("guard_rd_en", c, guard_rd_en_o, e_gen[c]);
      if (e_gen[c]) chk("guard_rd_addr", c, guard_rd_addr_o, e_gaddr[c]);
      chk("fm_rd_en", c, fm_rd_en_o, e_fen[c]);
      if (e_fen[c]) chk("fm_rd_addr", c, fm_rd_addr_o, e_faddr[c]);
      chk("act_valid", c, act_valid_o, e_valid[c]);
      if (e_valid[c]) begin
        chk("act_o", c, act_o, e_vec[c]);
        chk("act_guard", c, act_guard_o, e_gmask[c]);
      end
      chk("busy", c, busy_o, (c >= 1 && c < dc));
      chk("done", c, done_o, (c == dc));
      if (act_valid_o && first_valid < 0) first_valid = c;
      if (fm_rd_en_o) fm_reads++;
      if (done_o && done_cyc < 0) done_cyc = c;
      if (act_valid_o && act_ready_i) last_act = act_o;
    end
    start = 1'b0;
    act_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [15:0] bf;
    logic [13:0] bg;
    logic [15:0] ng;
    logic [5:0]  guard;
    int          stall;
    int          exp_valid;
    int          exp_reads;
    int          exp_done;
    logic [47:0] exp_act;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int fv, nr, dn;
    logic [47:0] la;
    bit seen;

    rst_n = 1'b0; start = 1'b0; act_ready_i = 1'b0;
    base_fm_addr_i = '0; base_guard_addr_i = '0; group_num_i = '0;
    for (int a = 0; a < 65536; a++) fmem[a] = 8'($urandom);
    for (int a = 0; a < 16384; a++) gmem[a] = 6'($urandom);

    #2;
    chk("rst_busy", 0, busy_o, 0);
    chk("rst_done", 0, done_o, 0);
    chk("rst_strobes", 0, {guard_rd_en_o, fm_rd_en_o, act_valid_o}, 0);
    chk("rst_addrs", 0, {guard_rd_addr_o, fm_rd_addr_o}, 0);
    chk("rst_act", 0, act_o, 0);
    chk("rst_act_guard", 0, act_guard_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: full, zero, sparse, backpressure, wrap, empty job.
    tbl[0] = '{16'h0100, 14'h0010, 16'd1, 6'h3F, 0, 10,  6, 11, 48'h060504030201};
    tbl[1] = '{16'h0180, 14'h0020, 16'd1, 6'h00, 0,  3,  0,  4, 48'h000000000000};
    tbl[2] = '{16'h0200, 14'h0030, 16'd1, 6'h21, 0,  6,  2,  7, 48'h5500000000AA};
    tbl[3] = '{16'h0300, 14'h0040, 16'd2, 6'h03, 5,  6,  4, 23, 48'h000000002211};
    tbl[4] = '{16'hFFFA, 14'h3FFF, 16'd3, 6'h3F, 0, 10, 18, 31, 48'h363534333231};
    tbl[5] = '{16'h0400, 14'h0050, 16'd0, 6'h3F, 0, -1,  0,  1, 48'h000000000000};
    for (int i = 0; i < 6; i++) fmem[16'h0100 + i] = 8'(i + 1);
    fmem[16'h0200] = 8'hAA; fmem[16'h0205] = 8'h55;
    fmem[16'h0306] = 8'h11; fmem[16'h0307] = 8'h22;
    for (int i = 0; i < 6; i++) fmem[16'h0006 + i] = 8'(8'h31 + i);

    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < int'(tbl[i].ng); g++) gmem[14'(int'(tbl[i].bg) + g)] = tbl[i].guard;
      run_job(tbl[i].bf, tbl[i].bg, tbl[i].ng, tbl[i].stall, 1'b0, fv, nr, dn, la);
      chk($sformatf("tbl%0d_valid_cycle", i), i, 64'(fv), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_fm_reads", i), i, 64'(nr), 64'(tbl[i].exp_reads));
      chk($sformatf("tbl%0d_done_cycle", i), i, 64'(dn), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_last_act", i), i, la, tbl[i].exp_act);
    end

    // Reset in the middle of an FM fetch.
    gmem[14'h0200] = 6'h3F;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      base_fm_addr_i = 16'h2000; base_guard_addr_i = 14'h0200; group_num_i = 16'd4;
      @(negedge clk);
      if (fm_rd_en_o) seen = 1;
    end
    chk("reach_frd", 0, seen, 1);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_done", 0, {busy_o, done_o}, 0);
    chk("mid_rst_strobes", 0, {guard_rd_en_o, fm_rd_en_o, act_valid_o}, 0);
    chk("mid_rst_addrs", 0, {guard_rd_addr_o, fm_rd_addr_o}, 0);
    chk("mid_rst_act", 0, act_o, 0);
    chk("mid_rst_act_guard", 0, act_guard_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_strobes", 0, {guard_rd_en_o, fm_rd_en_o, busy_o}, 0);
    run_job(16'h4321, 14'h1234, 16'd2, -1, 1'b0, fv, nr, dn, la);

    // Randomized jobs with random stalls and scrambled inputs while busy.
    for (int j = 0; j < 25; j++) begin
      logic [15:0] bf, ng;
      logic [13:0] bg;
      bf = (j % 4 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      bg = (j % 4 == 1) ? 14'(14'h3FFC + $urandom_range(0, 3)) : 14'($urandom);
      ng = 16'($urandom_range(0, 6));
      for (int g = 0; g < int'(ng); g++) begin
        case ($urandom_range(0, 3))
          0: gmem[14'(int'(bg) + g)] = 6'h00;
          1: gmem[14'(int'(bg) + g)] = 6'h3F;
          default: gmem[14'(int'(bg) + g)] = 6'($urandom);
        endcase
      end
      run_job(bf, bg, ng, -1, 1'b1, fv, nr, dn, la);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
